uart_receive: RTL and testbench

- UART receiver: the downstream partner of uart_transmit. Consumes the serial `tx` line, samples mid-bit, and delivers 8N1 bytes (LSB first) as a parallel byte with a one-cycle valid strobe.
- Same parameterisation style as the transmitter (clock frequency and baud rate), so a TX/RX pair built with identical parameters loops back cleanly.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_receive.sv | 191 +++++++++++++++++++
 tb/tb_uart_receive.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, defaults and baud helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int DEFAULT_CLK_FREQ = 4_992_000;
  localparam int DEFAULT_BAUD     = 9600;

  // Whole clock cycles per bit; the fractional part is dropped.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values simply shift the line one stage down the chain.
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - 8N1 UART receiver with mid-bit sampling; UART_RX_PARITY_EN selects 8E1
module uart_receive
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] dataOut,
  output logic       dataValid,
  output logic       framingError,
  output logic       busy,
  output logic       parityError
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_receive: CLK_FREQ/BAUD must be at least 4");
  end

  logic rx_s;

  uart_rx_sync u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (rx),
    .sync_out (rx_s)
  );

  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             framing_error_q, framing_error_d;
`ifdef UART_RX_PARITY_EN
  logic             parity_bad_q, parity_bad_d;
  logic             parity_error_q, parity_error_d;
`endif

  // Frame sequencing: the start bit is checked at its midpoint, after which
  // every later sample lands one full bit period on, i.e. mid-bit.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shreg_d         = shreg_q;
    data_out_d      = data_out_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d    = parity_bad_q;
    parity_error_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Line went back high before mid-start: treat as noise.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == CNT_BIT_LAST) begin
          // Even parity: the parity bit must equal the XOR of the data bits.
          parity_bad_d = rx_s ^ (^shreg_q);
          cnt_d        = '0;
          state_d      = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            // Leave at mid-stop so a following start edge is not missed.
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad_q) begin
              parity_error_d = 1'b1;
            end else begin
              data_out_d   = shreg_q;
              data_valid_d = 1'b1;
            end
`else
            data_out_d   = shreg_q;
            data_valid_d = 1'b1;
`endif
          end else begin
            framing_error_d = 1'b1;
            state_d         = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        // Wait out a held-low line so it is not mistaken for a new start bit.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shreg_q         <= 8'h00;
      data_out_q      <= 8'h00;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q    <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shreg_q         <= shreg_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q    <= parity_bad_d;
      parity_error_q  <= parity_error_d;
`endif
    end
  end

  assign dataOut      = data_out_q;
  assign dataValid    = data_valid_q;
  assign framingError = framing_error_q;
  assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parityError  = parity_error_q;
`else
  assign parityError  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receive.sv
// tb/tb_uart_receive.sv - directed self-checking bench for uart_receive
module tb_uart_receive;

  localparam int CPB = 520;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       framingError;
  logic       busy;
  logic       parityError;

  uart_receive #(
    .CLK_FREQ (4_992_000),
    .BAUD     (9600)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx           (rx),
    .dataOut      (dataOut),
    .dataValid    (dataValid),
    .framingError (framingError),
    .busy         (busy),
    .parityError  (parityError)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int dv_count = 0;
  int fe_count = 0;
  int pe_count = 0;
  int both_count = 0;
  int dv_cyc[$];
  logic [7:0] dv_byte[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (dataValid === 1'b1) begin
      dv_count = dv_count + 1;
      dv_cyc.push_back(cyc);
      dv_byte.push_back(dataOut);
    end
    if (framingError === 1'b1) fe_count = fe_count + 1;
    if (parityError === 1'b1) pe_count = pe_count + 1;
    if (dataValid === 1'b1 && framingError === 1'b1) both_count = both_count + 1;
  end

  task automatic send_frame(input logic [7:0] data, input logic par,
                            input logic stop_val, input int stop_cycles);
    fall_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (CPB) @(negedge clock);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    rx = stop_val;
    repeat (stop_cycles) @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clock);
    n_cmp++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL reset_dataOut: got %h want 00", dataOut); end
    n_cmp++; if (dataValid !== 1'b0) begin n_fail++; $display("FAIL reset_dataValid: got %b want 0", dataValid); end
    n_cmp++; if (framingError !== 1'b0) begin n_fail++; $display("FAIL reset_framingError: got %b want 0", framingError); end
    n_cmp++; if (parityError !== 1'b0) begin n_fail++; $display("FAIL reset_parityError: got %b want 0", parityError); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_loopback();
    int dv0, fe0, lat;
    dv0 = dv_count;
    fe0 = fe_count;
    send_frame(8'h0D, 1'b1, 1'b1, CPB);
    repeat (20) @(negedge clock);
    n_cmp++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL loop_pulses: got %0d want 1", dv_count - dv0); end
    n_cmp++; if (dataOut !== 8'h0D) begin n_fail++; $display("FAIL loop_dataOut: got %h want 0d", dataOut); end
    lat = (dv_count > dv0) ? dv_cyc[dv_cyc.size()-1] - fall_cyc : -1;
    n_cmp++; if (lat < 4940 || lat > 4944) begin n_fail++; $display("FAIL loop_latency: got %0d want 4940..4944", lat); end
    n_cmp++; if (fe_count - fe0 !== 0) begin n_fail++; $display("FAIL loop_framing: got %0d want 0", fe_count - fe0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL loop_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    int dv0, fe0;
    dv0 = dv_count;
    fe0 = fe_count;
    rx = 1'b0;
    repeat (50) @(negedge clock);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    repeat (50) @(negedge clock);
    rx = 1'b1;
    repeat (170) @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
    n_cmp++; if (dv_count - dv0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d want 0", dv_count - dv0); end
    n_cmp++; if (fe_count - fe0 !== 0) begin n_fail++; $display("FAIL glitch_framing: got %0d want 0", fe_count - fe0); end
  endtask

  task automatic test_framing_error();
    int dv0, fe0;
    dv0 = dv_count;
    fe0 = fe_count;
    send_frame(8'hA5, 1'b0, 1'b0, 2000);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fe_busy_held: got %b want 1", busy); end
    n_cmp++; if (fe_count - fe0 !== 1) begin n_fail++; $display("FAIL fe_pulses: got %0d want 1", fe_count - fe0); end
    n_cmp++; if (dataOut !== 8'h0D) begin n_fail++; $display("FAIL fe_dataOut_kept: got %h want 0d", dataOut); end
    rx = 1'b1;
    repeat (10) @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fe_busy_release: got %b want 0", busy); end
    repeat (11 * CPB) @(negedge clock);
    n_cmp++; if (dv_count - dv0 !== 0) begin n_fail++; $display("FAIL fe_spurious_frame: got %0d want 0", dv_count - dv0); end
    n_cmp++; if (fe_count - fe0 !== 1) begin n_fail++; $display("FAIL fe_pulses_after: got %0d want 1", fe_count - fe0); end
  endtask

  task automatic test_back_to_back();
    int dv0, gap;
    dv0 = dv_count;
    send_frame(8'h55, 1'b0, 1'b1, CPB);
    send_frame(8'hA3, 1'b0, 1'b1, CPB);
    repeat (20) @(negedge clock);
    n_cmp++; if (dv_count - dv0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", dv_count - dv0); end
    if (dv_count - dv0 == 2) begin
      n_cmp++; if (dv_byte[dv0] !== 8'h55) begin n_fail++; $display("FAIL b2b_first: got %h want 55", dv_byte[dv0]); end
      n_cmp++; if (dv_byte[dv0+1] !== 8'hA3) begin n_fail++; $display("FAIL b2b_second: got %h want a3", dv_byte[dv0+1]); end
      gap = dv_cyc[dv0+1] - dv_cyc[dv0];
      n_cmp++; if (gap < 5199 || gap > 5201) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 5200", gap); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int dv0, fe0;
    dv0 = dv_count;
    fe0 = fe_count;
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clock);
    end
    repeat (CPB / 2) @(negedge clock);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before: got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_async: got %b want 0", busy); end
    n_cmp++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL rst_dataOut: got %h want 00", dataOut); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (11 * CPB) @(negedge clock);
    n_cmp++; if (dv_count - dv0 !== 0) begin n_fail++; $display("FAIL rst_no_valid: got %0d want 0", dv_count - dv0); end
    n_cmp++; if (fe_count - fe0 !== 0) begin n_fail++; $display("FAIL rst_no_framing: got %0d want 0", fe_count - fe0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_after: got %b want 0", busy); end
    n_cmp++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL rst_dataOut_after: got %h want 00", dataOut); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int dv0, pe0;
    dv0 = dv_count;
    pe0 = pe_count;
    send_frame(8'h07, 1'b1, 1'b1, CPB);
    repeat (20) @(negedge clock);
    n_cmp++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL par_good_valid: got %0d want 1", dv_count - dv0); end
    n_cmp++; if (dataOut !== 8'h07) begin n_fail++; $display("FAIL par_good_data: got %h want 07", dataOut); end
    n_cmp++; if (pe_count - pe0 !== 0) begin n_fail++; $display("FAIL par_good_perr: got %0d want 0", pe_count - pe0); end
    dv0 = dv_count;
    send_frame(8'h07, 1'b0, 1'b1, CPB);
    repeat (20) @(negedge clock);
    n_cmp++; if (pe_count - pe0 !== 1) begin n_fail++; $display("FAIL par_bad_perr: got %0d want 1", pe_count - pe0); end
    n_cmp++; if (dv_count - dv0 !== 0) begin n_fail++; $display("FAIL par_bad_valid: got %0d want 0", dv_count - dv0); end
    n_cmp++; if (dataOut !== 8'h07) begin n_fail++; $display("FAIL par_bad_data: got %h want 07", dataOut); end
`else
    n_cmp++; if (pe_count !== 0) begin n_fail++; $display("FAIL par_tied_low: got %0d pulses want 0", pe_count); end
`endif
  endtask

  task automatic test_exclusive();
    n_cmp++; if (both_count !== 0) begin n_fail++; $display("FAIL valid_and_framing: got %0d overlaps want 0", both_count); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_parity();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
